// File: rtl/btn_toggle_bank_if.sv
// -----------------------------------------------------------------------------
// btn_toggle_bank_if
//   Groups the button-side inputs and LED-side outputs of btn_toggle_bank.
//
//   Signals (CHANNELS bits wide unless noted):
//     btn         raw asynchronous button levels, 1 = pressed
//     mode        per-channel mode, 0 = toggle, 1 = momentary
//     clear       (1 bit) synchronous clear of all toggle states
//     led         per-channel output level
//     press_pulse one-cycle strobe on each debounced press
//     long_press  one-cycle strobe when a hold reaches the long-press threshold
//
//   Modports:
//     master  the board / environment side (drives btn, mode, clear)
//     slave   the btn_toggle_bank side (drives led, press_pulse, long_press)
// -----------------------------------------------------------------------------
interface btn_toggle_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] btn;
    logic [CHANNELS-1:0] mode;
    logic                clear;
    logic [CHANNELS-1:0] led;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] long_press;

    modport master (
        output btn, mode, clear,
        input  led, press_pulse, long_press
    );

    modport slave (
        input  btn, mode, clear,
        output led, press_pulse, long_press
    );
endinterface

// File: rtl/btn_toggle_bank.sv
// -----------------------------------------------------------------------------
// btn_toggle_bank
//   Multi-channel push-button front end. Each channel synchronises its raw
//   button, debounces it with a stable-cycle counter, detects the debounced
//   rising edge and drives an LED either as a toggle or as a momentary follow.
//
//   Ports:
//     clk    system clock, all logic on the rising edge
//     reset  asynchronous, active-high reset
//     bus    btn_toggle_bank_if.slave: btn, mode, clear in;
//            led, press_pulse, long_press out
//
//   Strobe semantics: press_pulse[i] and long_press[i] are registered and
//   high for exactly one clock; there is no back-pressure, a consumer that
//   does not sample the strobe in that cycle misses the event.
//
//   Optional build macro: BTN_TOGGLE_BANK_LONG_PRESS_EN
//     defined   per-channel hold counters drive long_press
//     undefined long_press is tied to 0 (port list unchanged)
// -----------------------------------------------------------------------------
module btn_toggle_bank #(
    parameter int CHANNELS          = 4,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int SYNC_STAGES       = 2,
    parameter int LONG_PRESS_CYCLES = 1024
) (
    input logic               clk,
    input logic               reset,
    btn_toggle_bank_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which a persistent difference is accepted as the new level.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Illegal parameterisations stop elaboration instead of building odd hardware.
    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || LONG_PRESS_CYCLES < 1) begin : g_param_check
        $error("btn_toggle_bank: illegal parameter value");
    end

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 samples the raw pins, last stage is s.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.btn;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debouncer, press detect and toggle state
    // ------------------------------------------------------------------
    logic [CW-1:0]       cnt [CHANNELS];
    logic [CHANNELS-1:0] deb;
    logic [CHANNELS-1:0] tog;
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] rise;

    // rise marks the edge on which the debounced level goes 0 -> 1.
    always_comb begin
        rise = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            rise[ch] = s[ch] & ~deb[ch] & (cnt[ch] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt[ch] <= '0;
            end
            deb     <= '0;
            tog     <= '0;
            press_q <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (s[ch] == deb[ch]) begin
                    // Input agrees with the accepted level: any partial count
                    // was a glitch and is discarded.
                    cnt[ch] <= '0;
                end else if (cnt[ch] == CNT_LAST) begin
                    deb[ch] <= s[ch];
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + 1'b1;
                end
            end
            press_q <= rise;
            // clear beats a simultaneous press; the strobe is unaffected.
            if (bus.clear) begin
                tog <= '0;
            end else begin
                tog <= tog ^ (rise & ~bus.mode);
            end
        end
    end

    assign bus.press_pulse = press_q;
    // Combinational mux so a mode change shows up in the same cycle.
    assign bus.led = (bus.mode & deb) | (~bus.mode & tog);

    // ------------------------------------------------------------------
    // Long-press detection
    // ------------------------------------------------------------------
`ifdef BTN_TOGGLE_BANK_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0]       hold [CHANNELS];
    logic [CHANNELS-1:0] long_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hold[ch] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (!deb[ch]) begin
                    hold[ch]   <= '0;
                    long_q[ch] <= 1'b0;
                end else if (hold[ch] != HOLD_MAX) begin
                    // Saturating at HOLD_MAX guarantees one strobe per hold.
                    hold[ch]   <= hold[ch] + 1'b1;
                    long_q[ch] <= (hold[ch] == HOLD_MAX - 1'b1);
                end else begin
                    long_q[ch] <= 1'b0;
                end
            end
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = '0;
`endif

endmodule

// File: tb/tb_btn_toggle_bank.sv
// -----------------------------------------------------------------------------
// tb_btn_toggle_bank
//   Directed scenarios followed by a randomized phase. Every clock edge is
//   mirrored by a sliding-window reference model: the debounced level flips
//   when the last DEB synchronised samples all disagree with it.
// -----------------------------------------------------------------------------
module tb_btn_toggle_bank;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 8;
    localparam int HL   = SYNC + DEB;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    btn_toggle_bank_if #(.CHANNELS(CH)) bus ();

    btn_toggle_bank #(
        .CHANNELS          (CH),
        .DEBOUNCE_CYCLES   (DEB),
        .SYNC_STAGES       (SYNC),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic          hist [CH][HL];   // hist[c][0] = newest btn sample
    logic [CH-1:0] m_d;
    logic [CH-1:0] m_t;
    logic [CH-1:0] m_pulse;
    logic [CH-1:0] m_long;
    int            m_hold [CH];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
            m_hold[c] = 0;
        end
        m_d = '0; m_t = '0; m_pulse = '0; m_long = '0;
    endtask

    task automatic model_edge();
        logic all_diff;
        for (int c = 0; c < CH; c++) begin
            for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = bus.btn[c];
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hist[c][SYNC+j] == m_d[c]) all_diff = 1'b0;
            end
            m_pulse[c] = all_diff & ~m_d[c];
            if (m_d[c]) m_hold[c]++;
            else        m_hold[c] = 0;
            m_long[c] = m_d[c] && (m_hold[c] == LONG);
            if (bus.clear)                       m_t[c] = 1'b0;
            else if (m_pulse[c] && !bus.mode[c]) m_t[c] = ~m_t[c];
            if (all_diff) m_d[c] = ~m_d[c];
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] exp_led;
        logic [CH-1:0] exp_long;
        exp_led = (bus.mode & m_d) | (~bus.mode & m_t);
`ifdef BTN_TOGGLE_BANK_LONG_PRESS_EN
        exp_long = m_long;
`else
        exp_long = '0;
`endif
        chk("led", bus.led, exp_led);
        chk("press_pulse", bus.press_pulse, m_pulse);
        chk("long_press", bus.long_press, exp_long);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        ticks(2);
        rst = 1'b0;
    endtask

    // Runs up to budget edges; lat = 1-based edge of first press_pulse[ch].
    task automatic wait_press(input int ch, input int budget, output int lat, output int npulse);
        lat = -1;
        npulse = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.press_pulse[ch]) begin
                npulse++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int np;
        int nlong;
        int long_at;

        rst = 1'b1;
        bus.btn = '0;
        bus.mode = '0;
        bus.clear = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_led", bus.led, 0);
        ticks(3);
        rst = 1'b0;

        // Clean press on channel 0, toggle mode.
        bus.btn[0] = 1'b1;
        wait_press(0, 12, lat, np);
        chk("clean_latency", lat, SYNC + DEB);
        chk("clean_npulse", np, 1);
        chk("clean_led", bus.led, 4'b0001);
        bus.btn[0] = 1'b0;
        ticks(10);

        // Bounce rejection on channel 1.
        np = 0;
        for (int i = 0; i < 8; i++) begin
            bus.btn[1] = (i % 2 == 0);
            tick();
            if (bus.press_pulse[1]) np++;
        end
        chk("bounce_no_pulse", np, 0);
        bus.btn[1] = 1'b1;
        wait_press(1, 12, lat, np);
        chk("bounce_latency", lat, SYNC + DEB);
        chk("bounce_npulse", np, 1);
        chk("bounce_led1", bus.led[1], 1);
        bus.btn[1] = 1'b0;
        ticks(10);

        // Toggle mode on channel 2: two presses.
        do_reset();
        bus.btn[2] = 1'b1;
        wait_press(2, 10, lat, np);
        chk("tog_first_pulse", np, 1);
        chk("tog_led_on", bus.led[2], 1);
        bus.btn[2] = 1'b0;
        ticks(10);
        chk("tog_led_hold", bus.led[2], 1);
        bus.btn[2] = 1'b1;
        wait_press(2, 10, lat, np);
        chk("tog_second_pulse", np, 1);
        chk("tog_led_off", bus.led[2], 0);
        bus.btn[2] = 1'b0;
        ticks(10);

        // Momentary on channel 3, then switch mode while held.
        bus.mode[3] = 1'b1;
        bus.btn[3] = 1'b1;
        wait_press(3, 10, lat, np);
        chk("mom_pulse", np, 1);
        chk("mom_led_on", bus.led[3], 1);
        bus.mode[3] = 1'b0;
        #1;
        chk("mom_switch_led", bus.led[3], 0);
        ticks(2);
        bus.mode[3] = 1'b1;
        bus.btn[3] = 1'b0;
        ticks(10);
        chk("mom_led_off", bus.led[3], 0);
        bus.mode[3] = 1'b0;

        // Clear colliding with a press.
        do_reset();
        bus.btn = 4'b1111;
        wait_press(0, 8, lat, np);
        chk("multi_led", bus.led, 4'b1111);
        bus.btn = '0;
        ticks(10);
        bus.btn[0] = 1'b1;
        ticks(SYNC + DEB - 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clear_led", bus.led, 4'b0000);
        chk("clear_pulse", bus.press_pulse[0], 1);
        bus.btn[0] = 1'b0;
        ticks(10);

        // Reset mid-count while button held.
        bus.btn[0] = 1'b1;
        ticks(4);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_mid_led", bus.led, 0);
        chk("rst_mid_pulse", bus.press_pulse, 0);
        ticks(2);
        rst = 1'b0;
        wait_press(0, 12, lat, np);
        chk("rst_mid_latency", lat, SYNC + DEB);
        bus.btn[0] = 1'b0;
        ticks(10);

        // Long hold on channel 0.
        do_reset();
        bus.btn[0] = 1'b1;
        wait_press(0, SYNC + DEB, lat, np);
        nlong = 0;
        long_at = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.long_press[0]) begin
                nlong++;
                if (long_at < 0) long_at = i;
            end
        end
`ifdef BTN_TOGGLE_BANK_LONG_PRESS_EN
        chk("long_count", nlong, 1);
        chk("long_at", long_at, LONG);
`else
        chk("long_count", nlong, 0);
`endif
        chk("long_led", bus.led[0], 1);
        bus.btn[0] = 1'b0;
        ticks(10);

        // Randomized phase.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 11) == 0) bus.btn[c] = ~bus.btn[c];
                if ($urandom_range(0, 199) == 0) bus.mode[c] = ~bus.mode[c];
            end
            bus.clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end
        bus.clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
